// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the two-requester memory port arbiter.
// Source IDs, grant-state encodings, SRAM size codes and the request payload.
package mem_port_arbiter_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;
  localparam int unsigned SIZE_W = 2;

  localparam logic SRC_INST = 1'b0;
  localparam logic SRC_DATA = 1'b1;

  localparam logic [SIZE_W-1:0] SIZE_BYTE = 2'd0;
  localparam logic [SIZE_W-1:0] SIZE_HALF = 2'd1;
  localparam logic [SIZE_W-1:0] SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {
    NONE   = 2'd0,
    LOCK_I = 2'd1,
    LOCK_D = 2'd2
  } grant_state_e;

  typedef struct packed {
    logic              wr;
    logic [SIZE_W-1:0] size;
    logic [STRB_W-1:0] wstrb;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_cmd_t;

  // Lock state that holds the given source through a stalled address phase.
  function automatic grant_state_e lock_state(input logic src);
    return (src == SRC_DATA) ? LOCK_D : LOCK_I;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// One req/addr_ok/data_ok split-handshake port. The master issues requests,
// the slave accepts addresses and returns responses.
interface mem_port_arbiter_if;
  import mem_port_arbiter_pkg::*;

  logic              req;
  logic              wr;
  logic [SIZE_W-1:0] size;
  logic [STRB_W-1:0] wstrb;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              addr_ok;
  logic              data_ok;
  logic [DATA_W-1:0] rdata;

  modport master (output req, wr, size, wstrb, addr, wdata,
                  input  addr_ok, data_ok, rdata);
  modport slave  (input  req, wr, size, wstrb, addr, wdata,
                  output addr_ok, data_ok, rdata);
endinterface

// File: rtl/mem_port_arbiter_id_fifo.sv
// In-order FIFO of 1-bit source IDs for accepted-but-unreturned transactions.
// Push on full and pop on empty are ignored.
module mem_port_arbiter_id_fifo #(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             din,
  input  logic             pop,
  output logic             head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [DEPTH-1:0] mem_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage needs no reset; only slots below count are ever read as valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one SRAM-like port between instruction fetch and data requesters:
// data-first priority with a starvation limit, in-order response routing.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned OUTSTANDING = 4,
  parameter int unsigned STARVE_MAX  = 4
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   inst,
  mem_port_arbiter_if.slave   data,
  mem_port_arbiter_if.master  mem,
  output logic                busy
);

  localparam int unsigned CNT_W = $clog2(OUTSTANDING) + 1;
  localparam int unsigned SC_W  = $clog2(STARVE_MAX + 1);

  grant_state_e     state_q;
  grant_state_e     state_d;
  logic             grant_vld;
  logic             grant_src;
  logic             accept;
  logic [SC_W-1:0]  starve_q;
  logic             starve_sat;
  logic             fifo_head;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full;
  logic             fifo_empty;
  logic             rsp_pop;
  mem_cmd_t         inst_cmd;
  mem_cmd_t         data_cmd;
  mem_cmd_t         sel_cmd;

  assign starve_sat = (starve_q == SC_W'(STARVE_MAX));
  assign accept     = grant_vld && mem.addr_ok;

  always_ff @(posedge clk) begin
    if (rst) state_q <= NONE;
    else     state_q <= state_d;
  end

  // Grant selection; a stalled address phase locks the grant until accepted.
  always_comb begin
    grant_vld = 1'b0;
    grant_src = SRC_INST;
    state_d   = state_q;
    case (state_q)
      NONE: begin
        if (!fifo_full) begin
          if (data.req && !(inst.req && starve_sat)) begin
            grant_vld = 1'b1;
            grant_src = SRC_DATA;
          end else if (inst.req) begin
            grant_vld = 1'b1;
            grant_src = SRC_INST;
          end
        end
      end
      LOCK_I: begin
        grant_vld = 1'b1;
        grant_src = SRC_INST;
      end
      LOCK_D: begin
        grant_vld = 1'b1;
        grant_src = SRC_DATA;
      end
      default: ;
    endcase
    if (grant_vld && !mem.addr_ok) state_d = lock_state(grant_src);
    else                           state_d = NONE;
  end

  // Consecutive data accepts while fetch waits; cleared when fetch wins or idles.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= '0;
    end else if (!inst.req) begin
      starve_q <= '0;
    end else if (accept && (grant_src == SRC_INST)) begin
      starve_q <= '0;
    end else if (accept && !starve_sat) begin
      starve_q <= starve_q + SC_W'(1);
    end
  end

  always_comb begin
    inst_cmd.wr    = inst.wr;
    inst_cmd.size  = inst.size;
    inst_cmd.wstrb = inst.wstrb;
    inst_cmd.addr  = inst.addr;
    inst_cmd.wdata = inst.wdata;
    data_cmd.wr    = data.wr;
    data_cmd.size  = data.size;
    data_cmd.wstrb = data.wstrb;
    data_cmd.addr  = data.addr;
    data_cmd.wdata = data.wdata;
    sel_cmd        = '0;
    if (grant_vld) sel_cmd = (grant_src == SRC_DATA) ? data_cmd : inst_cmd;
  end

  assign mem.req   = grant_vld;
  assign mem.wr    = sel_cmd.wr;
  assign mem.size  = sel_cmd.size;
  assign mem.wstrb = sel_cmd.wstrb;
  assign mem.addr  = sel_cmd.addr;
  assign mem.wdata = sel_cmd.wdata;

  assign inst.addr_ok = accept && (grant_src == SRC_INST);
  assign data.addr_ok = accept && (grant_src == SRC_DATA);

  mem_port_arbiter_id_fifo #(
    .DEPTH (OUTSTANDING)
  ) u_id_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .din   (grant_src),
    .pop   (rsp_pop),
    .head  (fifo_head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Responses with nothing outstanding are dropped.
  assign rsp_pop      = mem.data_ok && !fifo_empty;
  assign inst.data_ok = rsp_pop && (fifo_head == SRC_INST);
  assign data.data_ok = rsp_pop && (fifo_head == SRC_DATA);
  assign inst.rdata   = inst.data_ok ? mem.rdata : '0;
  assign data.rdata   = data.data_ok ? mem.rdata : '0;

  assign busy = (fifo_count != '0) || (state_q != NONE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: stimulus queues expected accepts and
// responses, a negedge monitor pops and compares them as the DUT presents them.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  typedef struct packed {
    logic        src;
    logic [31:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_acc[$];
  exp_t exp_rsp[$];
  logic [9:0] ord_v;

  always #5 clk = ~clk;

  mem_port_arbiter_if inst_bus ();
  mem_port_arbiter_if data_bus ();
  mem_port_arbiter_if mem_bus ();

  mem_port_arbiter #(
    .OUTSTANDING (4),
    .STARVE_MAX  (4)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .inst (inst_bus),
    .data (data_bus),
    .mem  (mem_bus),
    .busy (busy)
  );

  function automatic exp_t mk(input logic src, input logic [31:0] val);
    exp_t e;
    e.src = src;
    e.val = val;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_inst(input logic req, input logic [31:0] addr);
    inst_bus.req   = req;
    inst_bus.wr    = 1'b0;
    inst_bus.size  = SIZE_WORD;
    inst_bus.wstrb = 4'h0;
    inst_bus.addr  = addr;
    inst_bus.wdata = 32'h0;
  endtask

  task automatic drive_data(input logic req, input logic [31:0] addr);
    data_bus.req   = req;
    data_bus.wr    = req;
    data_bus.size  = SIZE_WORD;
    data_bus.wstrb = req ? 4'hF : 4'h0;
    data_bus.addr  = addr;
    data_bus.wdata = addr ^ 32'hA5A5_0000;
  endtask

  // Single-cycle request from one side, accepted immediately.
  task automatic issue(input logic src, input logic [31:0] addr);
    drive_inst(src == SRC_INST, addr);
    drive_data(src == SRC_DATA, addr);
    mem_bus.addr_ok = 1'b1;
    exp_acc.push_back(mk(src, addr));
    @(negedge clk);
    next();
    drive_inst(1'b0, 32'h0);
    drive_data(1'b0, 32'h0);
    mem_bus.addr_ok = 1'b0;
  endtask

  task automatic ret(input logic src, input logic [31:0] val);
    mem_bus.data_ok = 1'b1;
    mem_bus.rdata   = val;
    exp_rsp.push_back(mk(src, val));
    @(negedge clk);
    next();
    mem_bus.data_ok = 1'b0;
  endtask

  // Monitor: compare every accept and response against the scoreboard queues.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst) begin
      if (inst_bus.addr_ok || data_bus.addr_ok) begin
        chk1("acc_onehot", inst_bus.addr_ok & data_bus.addr_ok, 1'b0);
        chk1("acc_mem_req", mem_bus.req, 1'b1);
        if (exp_acc.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL acc_unexpected: got addr %h expected no accept", mem_bus.addr);
        end else begin
          e = exp_acc.pop_front();
          chk1("acc_src", data_bus.addr_ok, e.src);
          chk("acc_addr", mem_bus.addr, e.val);
        end
      end
      if (inst_bus.data_ok || data_bus.data_ok) begin
        chk1("rsp_onehot", inst_bus.data_ok & data_bus.data_ok, 1'b0);
        if (exp_rsp.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_unexpected: got inst=%b data=%b expected no response",
                   inst_bus.data_ok, data_bus.data_ok);
        end else begin
          e = exp_rsp.pop_front();
          chk1("rsp_src", data_bus.data_ok, e.src);
          chk("rsp_rdata", data_bus.data_ok ? data_bus.rdata : inst_bus.rdata, e.val);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    drive_inst(1'b0, 32'h0);
    drive_data(1'b0, 32'h0);
    mem_bus.addr_ok = 1'b0;
    mem_bus.data_ok = 1'b0;
    mem_bus.rdata   = 32'h0;
    ord_v = 10'b01111_01111;
    rst = 1'b1;
    next();
    next();
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk1("rst_mem_req", mem_bus.req, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_inst_addr_ok", inst_bus.addr_ok, 1'b0);
    chk1("rst_data_addr_ok", data_bus.addr_ok, 1'b0);
    chk1("rst_inst_data_ok", inst_bus.data_ok, 1'b0);
    chk1("rst_data_data_ok", data_bus.data_ok, 1'b0);
    chk("rst_mem_addr", mem_bus.addr, 32'h0);
    next();

    // Immediate accept: data wins over inst
    drive_inst(1'b1, 32'h0000_0100);
    drive_data(1'b1, 32'h0000_0200);
    mem_bus.addr_ok = 1'b1;
    exp_acc.push_back(mk(SRC_DATA, 32'h0000_0200));
    @(negedge clk);
    chk("t1_mem_addr", mem_bus.addr, 32'h0000_0200);
    chk1("t1_mem_wr", mem_bus.wr, 1'b1);
    chk("t1_mem_wstrb", 32'(mem_bus.wstrb), 32'hF);
    chk1("t1_inst_addr_ok", inst_bus.addr_ok, 1'b0);
    chk1("t1_data_addr_ok", data_bus.addr_ok, 1'b1);
    next();
    drive_inst(1'b0, 32'h0);
    drive_data(1'b0, 32'h0);
    mem_bus.addr_ok = 1'b0;
    mem_bus.data_ok = 1'b1;
    mem_bus.rdata   = 32'hDEAD_BEEF;
    exp_rsp.push_back(mk(SRC_DATA, 32'hDEAD_BEEF));
    @(negedge clk);
    chk1("t1_data_data_ok", data_bus.data_ok, 1'b1);
    chk("t1_data_rdata", data_bus.rdata, 32'hDEAD_BEEF);
    chk1("t1_inst_data_ok", inst_bus.data_ok, 1'b0);
    chk("t1_inst_rdata", inst_bus.rdata, 32'h0);
    next();
    mem_bus.data_ok = 1'b0;

    // Lock hold: inst stalled 3 cycles, data arrives in cycle 2
    drive_inst(1'b1, 32'h1C00_0000);
    for (int c = 1; c <= 3; c++) begin
      if (c == 2) drive_data(1'b1, 32'h0000_0300);
      @(negedge clk);
      chk("t2_mem_addr_hold", mem_bus.addr, 32'h1C00_0000);
      chk1("t2_no_accept", inst_bus.addr_ok | data_bus.addr_ok, 1'b0);
      next();
    end
    mem_bus.addr_ok = 1'b1;
    exp_acc.push_back(mk(SRC_INST, 32'h1C00_0000));
    @(negedge clk);
    chk1("t2_inst_addr_ok", inst_bus.addr_ok, 1'b1);
    next();
    drive_inst(1'b0, 32'h0);
    exp_acc.push_back(mk(SRC_DATA, 32'h0000_0300));
    @(negedge clk);
    chk1("t2_data_addr_ok", data_bus.addr_ok, 1'b1);
    next();
    drive_data(1'b0, 32'h0);
    mem_bus.addr_ok = 1'b0;
    ret(SRC_INST, 32'h11);
    ret(SRC_DATA, 32'h22);

    // Starvation: D,D,D,D,I,D,D,D,D,I with returns overlapping accepts
    for (int i = 0; i < 10; i++) begin
      drive_inst(1'b1, 32'h1000 + 32'(i));
      drive_data(1'b1, 32'h2000 + 32'(i));
      mem_bus.addr_ok = 1'b1;
      exp_acc.push_back(mk(ord_v[i], ord_v[i] ? 32'h2000 + 32'(i) : 32'h1000 + 32'(i)));
      if (i > 0) begin
        mem_bus.data_ok = 1'b1;
        mem_bus.rdata   = 32'h500 + 32'(i - 1);
        exp_rsp.push_back(mk(ord_v[i-1], 32'h500 + 32'(i - 1)));
      end
      @(negedge clk);
      chk1("t3_grant_src", data_bus.addr_ok, ord_v[i]);
      next();
    end
    drive_inst(1'b0, 32'h0);
    drive_data(1'b0, 32'h0);
    mem_bus.addr_ok = 1'b0;
    ret(ord_v[9], 32'h509);

    // Full FIFO: four data accepts, then no grant until one returns
    drive_inst(1'b1, 32'h3000);
    mem_bus.addr_ok = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive_data(1'b1, 32'h4000 + 32'(k));
      exp_acc.push_back(mk(SRC_DATA, 32'h4000 + 32'(k)));
      @(negedge clk);
      next();
    end
    @(negedge clk);
    chk1("t4_full_mem_req", mem_bus.req, 1'b0);
    chk1("t4_full_busy", busy, 1'b1);
    next();
    mem_bus.data_ok = 1'b1;
    mem_bus.rdata   = 32'h77;
    exp_rsp.push_back(mk(SRC_DATA, 32'h77));
    @(negedge clk);
    chk1("t4_pop_mem_req", mem_bus.req, 1'b0);
    chk1("t4_pop_data_ok", data_bus.data_ok, 1'b1);
    next();
    mem_bus.data_ok = 1'b0;
    exp_acc.push_back(mk(SRC_INST, 32'h3000));
    @(negedge clk);
    chk1("t4_reassert_mem_req", mem_bus.req, 1'b1);
    chk("t4_reassert_addr", mem_bus.addr, 32'h3000);
    next();
    drive_inst(1'b0, 32'h0);
    drive_data(1'b0, 32'h0);
    mem_bus.addr_ok = 1'b0;
    ret(SRC_DATA, 32'h78);
    ret(SRC_DATA, 32'h79);
    ret(SRC_DATA, 32'h7A);
    ret(SRC_INST, 32'h7B);

    // In-order routing I,D,I,D then a spurious return
    issue(SRC_INST, 32'h10);
    issue(SRC_DATA, 32'h20);
    issue(SRC_INST, 32'h30);
    issue(SRC_DATA, 32'h40);
    ret(SRC_INST, 32'h1);
    ret(SRC_DATA, 32'h2);
    ret(SRC_INST, 32'h3);
    ret(SRC_DATA, 32'h4);
    mem_bus.data_ok = 1'b1;
    mem_bus.rdata   = 32'h5;
    @(negedge clk);
    chk1("t5_spurious_inst", inst_bus.data_ok, 1'b0);
    chk1("t5_spurious_data", data_bus.data_ok, 1'b0);
    chk1("t5_idle_busy", busy, 1'b0);
    next();
    mem_bus.data_ok = 1'b0;

    // Reset mid-flight: two outstanding plus a data lock
    issue(SRC_INST, 32'h50);
    issue(SRC_DATA, 32'h60);
    drive_data(1'b1, 32'h70);
    @(negedge clk);
    chk1("t6_lock_mem_req", mem_bus.req, 1'b1);
    chk1("t6_pre_busy", busy, 1'b1);
    next();
    drive_data(1'b0, 32'h0);
    rst = 1'b1;
    next();
    rst = 1'b0;
    @(negedge clk);
    chk1("t6_post_busy", busy, 1'b0);
    chk1("t6_post_mem_req", mem_bus.req, 1'b0);
    next();
    mem_bus.data_ok = 1'b1;
    mem_bus.rdata   = 32'hBAD;
    @(negedge clk);
    chk1("t6_late_inst", inst_bus.data_ok, 1'b0);
    chk1("t6_late_data", data_bus.data_ok, 1'b0);
    next();
    mem_bus.data_ok = 1'b0;

    @(negedge clk);
    chk("acc_queue_drained", 32'(exp_acc.size()), 32'h0);
    chk("rsp_queue_drained", 32'(exp_rsp.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one SRAM-like memory port between the instruction-fetch requester (inst_*) and the execute-stage data requester (data_*).
- Each side uses the team's req/addr_ok/data_ok split handshake.
- Arbitrates address phases with data-first fixed priority plus an anti-starvation limit.
- Tracks outstanding transactions in an in-order source-ID FIFO so each data_ok/rdata return is routed to the requester that issued it.

Parameters:
- OUTSTANDING, 4: maximum accepted-but-unreturned memory transactions (power of two, 2..16).
- STARVE_MAX, 4: consecutive data grants allowed while inst_req is pending before inst is forced.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- inst_req, inst_wr  in  1 each  fetch request valid / write flag.
- inst_size  in  2  0=byte, 1=half, 2=word.
- inst_wstrb  in  4  byte write strobes.
- inst_addr, inst_wdata  in  32 each  address / write data.
- inst_addr_ok, inst_data_ok  out  1 each  address accepted / response valid.
- inst_rdata  out  32  read data.
- data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata  in  same as inst_*.
- data_addr_ok, data_data_ok  out  1 each.
- data_rdata  out  32.
- mem_req, mem_wr  out  1 each.
- mem_size  out  2.
- mem_wstrb  out  4.
- mem_addr, mem_wdata  out  32 each.
- mem_addr_ok, mem_data_ok  in  1 each.
- mem_rdata  in  32.
- busy  out  1  FIFO non-empty or lock held.

Behaviour:
- Reset: lock=NONE, FIFO empty (count=0, ptrs=0), starve_cnt=0.
  - All *_addr_ok, *_data_ok, mem_req and busy are 0 in the cycle after reset.
  - mem_* payload outputs are 0 while mem_req=0.
- Grant state machine, states NONE, LOCK_I, LOCK_D:
  - In NONE the combinational grant g is computed as follows.
    - If count==OUTSTANDING: g=none.
    - Else if data_req && !(inst_req && starve_cnt==STARVE_MAX): g=D.
    - Else if inst_req: g=I.
    - Else: none.
  - In LOCK_x, g=x unconditionally.
- Issue and lock transitions:
  - mem_req = (g!=none). mem_* payload is muxed combinationally from the granted side.
  - Zero-cycle request path.
  - If mem_req && !mem_addr_ok: next state LOCK_g. The requester must hold its payload stable until addr_ok; the arbiter never switches mid-handshake.
  - On mem_req && mem_addr_ok: next state NONE.
  - In the same cycle: push g (0=I, 1=D) into the FIFO, and assert <g>_addr_ok = 1 for that single cycle. The other side's addr_ok = 0.
- Starvation counter:
  - On a D accept while inst_req=1: starve_cnt++, saturating at STARVE_MAX.
  - On an I accept, or while inst_req=0: starve_cnt resets to 0.
- Response routing:
  - On mem_data_ok with count>0: pop the head.
  - Drive <head>_data_ok = 1 and <head>_rdata = mem_rdata in the same cycle, combinational.
  - The non-selected rdata is 0.
- Empty-FIFO response: mem_data_ok with count==0 is dropped. No data_ok is raised and count stays 0.
- Simultaneous push and pop in one cycle: count unchanged, both pointers advance.
- Full FIFO:
  - No new grant, so mem_req stays 0 in NONE.
  - A lock already held stays held. The lock was only entered with count<OUTSTANDING, and count cannot rise until its accept.
- Pointers are log2(OUTSTANDING) bits with natural wrap. count is log2(OUTSTANDING)+1 bits.
- Same-cycle accept and return: data_ok for an earlier transaction may coincide with addr_ok for a new one. Both outputs assert independently, even on the same side.
- A synchronous rst mid-transaction drops the lock and all FIFO entries. Late mem_data_ok after reset is dropped per the empty-FIFO rule.
- busy = (count!=0) || (state!=NONE).

Decomposition:
- Shared defines header gets the following.
  - SRC_INST=1'b0 and SRC_DATA=1'b1.
  - Grant-state encodings: NONE=2'd0, LOCK_I=2'd1, LOCK_D=2'd2.
  - SRAM size codes.
- One sub-module, id_fifo: 1-bit wide, OUTSTANDING deep synchronous FIFO with push/pop/head/count/full/empty, same clk/rst.

Test Plan:
- Read accepted immediately: data_req=1 and inst_req=1, mem_addr_ok=1.
  - Required: mem_addr=data_addr, data_addr_ok=1, inst_addr_ok=0.
  - Then mem_data_ok with mem_rdata=32'hDEADBEEF gives data_data_ok=1, data_rdata=32'hDEADBEEF, inst_data_ok=0.
- Lock hold: inst_req=1 (addr 32'h1C000000), mem_addr_ok=0 for 3 cycles, data_req raised in cycle 2.
  - Required: mem_addr stays 32'h1C000000 for all 3 cycles.
  - Accept goes to inst on cycle 4. Data is granted in the next cycle.
- Starvation: both requesting continuously, mem_addr_ok=1 every cycle, STARVE_MAX=4.
  - Grant order D,D,D,D,I,D,D,D,D,I.
- Full FIFO: 4 accepts with no mem_data_ok.
  - Required: mem_req=0 on the 5th cycle despite requests.
  - One mem_data_ok returns the oldest source. mem_req reasserts the following cycle.
- In-order routing: issue I,D,I,D, then return 4 mem_data_ok with rdata 1,2,3,4.
  - inst gets 1,3; data gets 2,4. A spurious 5th mem_data_ok raises no data_ok.
- Reset mid-flight: 2 outstanding plus LOCK_D active, pulse rst for 1 cycle.
  - Required: busy=0, mem_req=0 next cycle. A subsequent mem_data_ok is ignored.
